pwm_ramp_ctrl: RTL and testbench

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_ramp_ctrl.sv | 136 +++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp controller: walks duty_cycle toward an accepted target one
// step every STEP_DIV clocks, and ramps to zero whenever enable is dropped.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | duty holding, ready for a new target while enable is high
// RAMP     | stepping duty toward tgt on every step tick
// SHUTDOWN | stepping duty toward zero; runs to completion regardless of enable
// OFF      | duty held at zero until enable returns
module pwm_ramp_ctrl #(
    parameter int unsigned STEP_DIV  = 128,
    parameter int unsigned STEP_SIZE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] target_duty,
    input  logic       target_valid,
    output logic       target_ready,
    output logic [7:0] duty_cycle,
    output logic       ramping,
    output logic       done
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [7:0] STEP8 = 8'(STEP_SIZE);
    localparam logic [8:0] STEP9 = {1'b0, STEP8};

    typedef enum logic [1:0] {IDLE, RAMP, SHUTDOWN, OFF} state_t;

    state_t           state, state_nxt;
    logic [7:0]       tgt, tgt_nxt;
    logic [7:0]       duty_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             done_nxt;

    logic             tick;
    logic [8:0]       duty_up;
    logic [7:0]       duty_dn;
    logic [7:0]       ramp_val;
    logic [7:0]       shut_val;

    // Step arithmetic is done 9 bits wide so neither direction can wrap.
    always_comb begin
        tick     = (cnt == CNT_LAST);
        duty_up  = {1'b0, duty_cycle} + STEP9;
        duty_dn  = duty_cycle - STEP8;
        ramp_val = tgt;
        if (duty_cycle < tgt) begin
            if (duty_up < {1'b0, tgt})
                ramp_val = duty_up[7:0];
        end else begin
            if ({1'b0, duty_cycle} > ({1'b0, tgt} + STEP9))
                ramp_val = duty_dn;
        end
        shut_val = ({1'b0, duty_cycle} > STEP9) ? duty_dn : 8'd0;
    end

    always_comb begin
        state_nxt    = state;
        tgt_nxt      = tgt;
        duty_nxt     = duty_cycle;
        cnt_nxt      = cnt;
        done_nxt     = 1'b0;
        target_ready = (state == IDLE) && enable;
        ramping      = (state == RAMP) || (state == SHUTDOWN);

        case (state)
            IDLE: begin
                if (!enable) begin
                    tgt_nxt   = 8'd0;
                    cnt_nxt   = '0;
                    state_nxt = (duty_cycle == 8'd0) ? OFF : SHUTDOWN;
                end else if (target_valid) begin
                    tgt_nxt   = target_duty;
                    cnt_nxt   = '0;
                    state_nxt = RAMP;
                end
            end
            RAMP: begin
                if (!enable) begin
                    tgt_nxt   = 8'd0;
                    cnt_nxt   = '0;
                    state_nxt = (duty_cycle == 8'd0) ? OFF : SHUTDOWN;
                end else if (duty_cycle == tgt) begin
                    // target already matched at acceptance: finish without a step
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = tick ? '0 : cnt + 1'b1;
                    if (tick) begin
                        duty_nxt = ramp_val;
                        if (ramp_val == tgt) begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            SHUTDOWN: begin
                cnt_nxt = tick ? '0 : cnt + 1'b1;
                if (tick) begin
                    duty_nxt = shut_val;
                    if (shut_val == 8'd0) begin
                        cnt_nxt   = '0;
                        state_nxt = OFF;
                    end
                end
            end
            OFF: begin
                if (enable)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tgt        <= 8'd0;
            duty_cycle <= 8'd0;
            cnt        <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            tgt        <= tgt_nxt;
            duty_cycle <= duty_nxt;
            cnt        <= cnt_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed scenarios then random traffic, each edge
// predicted by a trajectory model and checked through a scoreboard queue.
module tb_pwm_ramp_ctrl;

    localparam int SD = 4;
    localparam int SS = 3;

    localparam int M_IDLE = 0;
    localparam int M_RAMP = 1;
    localparam int M_SHUT = 2;
    localparam int M_OFF  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [7:0] target_duty = 8'd0;
    logic       target_valid = 1'b0;
    logic       target_ready;
    logic [7:0] duty_cycle;
    logic       ramping;
    logic       done;

    pwm_ramp_ctrl #(.STEP_DIV(SD), .STEP_SIZE(SS)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .target_duty  (target_duty),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .duty_cycle   (duty_cycle),
        .ramping      (ramping),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] duty;
        logic       ramping;
        logic       done;
        logic       ready;
        int         edge_no;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model: duty is a closed-form function of (start duty, target, ticks elapsed).
    int m_mode = M_IDLE;
    int m_duty = 0;
    int m_tgt  = 0;
    int m_d0   = 0;
    int m_t0   = 0;
    int m_edge = 0;
    bit m_done = 1'b0;
    bit m_accepted = 1'b0;

    function automatic int traj(input int d0, input int tg, input int k);
        int v;
        if (d0 <= tg) begin
            v = d0 + k * SS;
            return (v > tg) ? tg : v;
        end
        v = d0 - k * SS;
        return (v < tg) ? tg : v;
    endfunction

    task automatic begin_shutdown();
        m_mode = (m_duty == 0) ? M_OFF : M_SHUT;
        m_d0   = m_duty;
        m_t0   = m_edge;
    endtask

    task automatic model_edge();
        int   k;
        exp_t e;
        m_edge++;
        m_done     = 1'b0;
        m_accepted = 1'b0;
        if (reset) begin
            m_mode = M_IDLE;
            m_duty = 0;
            m_tgt  = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (!enable) begin_shutdown();
                    else if (target_valid) begin
                        m_tgt      = int'(target_duty);
                        m_d0       = m_duty;
                        m_t0       = m_edge;
                        m_mode     = M_RAMP;
                        m_accepted = 1'b1;
                    end
                end
                M_RAMP: begin
                    if (!enable) begin_shutdown();
                    else begin
                        k      = (m_edge - m_t0) / SD;
                        m_duty = traj(m_d0, m_tgt, k);
                        if (m_duty == m_tgt) begin
                            m_mode = M_IDLE;
                            m_done = 1'b1;
                        end
                    end
                end
                M_SHUT: begin
                    k      = (m_edge - m_t0) / SD;
                    m_duty = traj(m_d0, 0, k);
                    if (m_duty == 0) m_mode = M_OFF;
                end
                default: begin
                    if (enable) m_mode = M_IDLE;
                end
            endcase
        end
        e.duty    = 8'(m_duty);
        e.ramping = (m_mode == M_RAMP) || (m_mode == M_SHUT);
        e.done    = m_done;
        e.ready   = (m_mode == M_IDLE) && enable;
        e.edge_no = m_edge;
        sb.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic en, input logic v, input logic [7:0] d);
        @(negedge clk);
        #1;
        reset        = r;
        enable       = en;
        target_valid = v;
        target_duty  = d;
        model_edge();
    endtask

    task automatic accept(input logic [7:0] d);
        int n = 0;
        do begin
            cycle(1'b0, 1'b1, 1'b1, d);
            n++;
        end while (!m_accepted && n < 2000);
        if (!m_accepted) begin
            miscompares++;
            $display("FAIL accept_timeout: target %0d not accepted by model after %0d cycles", d, n);
        end
    endtask

    task automatic run_until_mode(input int mode, input logic en);
        int n = 0;
        while (m_mode != mode && n < 2000) begin
            cycle(1'b0, en, 1'b0, 8'd0);
            n++;
        end
    endtask

    // Monitor: one scoreboard entry per clock edge, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (duty_cycle !== e.duty || ramping !== e.ramping ||
                    done !== e.done || target_ready !== e.ready) begin
                    miscompares++;
                    $display("FAIL edge_out @edge %0d: got duty=%0d ramping=%b done=%b ready=%b, want duty=%0d ramping=%b done=%b ready=%b",
                             e.edge_no, duty_cycle, ramping, done, target_ready,
                             e.duty, e.ramping, e.done, e.ready);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached with %0d entries pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic       rv;
        logic       ren;
        logic       rr;
        logic [7:0] rd;

        cycle(1'b1, 1'b1, 1'b0, 8'd0);
        cycle(1'b1, 1'b1, 1'b1, 8'd77);
        cycle(1'b0, 1'b1, 1'b0, 8'd0);

        accept(8'd64);  run_until_mode(M_IDLE, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 8'd0);
        accept(8'd60);  run_until_mode(M_IDLE, 1'b1);
        accept(8'd60);  run_until_mode(M_IDLE, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 8'd0);
        accept(8'd250); run_until_mode(M_IDLE, 1'b1);
        accept(8'd255); run_until_mode(M_IDLE, 1'b1);

        // a target held during a ramp waits for IDLE
        accept(8'd10);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b1, 8'd100);
        accept(8'd100); run_until_mode(M_IDLE, 1'b1);

        // drop enable mid-ramp, re-raise during shutdown, then leave OFF
        accept(8'd0);
        while (m_duty > 30 && m_mode == M_RAMP) cycle(1'b0, 1'b1, 1'b0, 8'd0);
        cycle(1'b0, 1'b0, 1'b1, 8'd200);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, 8'd200);
        run_until_mode(M_OFF, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'd0);
        cycle(1'b0, 1'b1, 1'b0, 8'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        cycle(1'b0, 1'b1, 1'b0, 8'd0);
        cycle(1'b0, 1'b1, 1'b0, 8'd0);

        // reset mid-ramp, including a reset coinciding with an acceptance
        accept(8'd120);
        while (m_duty < 40 && m_mode == M_RAMP) cycle(1'b0, 1'b1, 1'b0, 8'd0);
        cycle(1'b1, 1'b1, 1'b0, 8'd0);
        cycle(1'b1, 1'b1, 1'b1, 8'd90);
        cycle(1'b0, 1'b1, 1'b0, 8'd0);

        rv  = 1'b0;
        ren = 1'b1;
        rd  = 8'd0;
        for (int i = 0; i < 15000; i++) begin
            rr = ($urandom_range(0, 399) == 0);
            if (ren ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 29) == 0))
                ren = ~ren;
            if (!rv && $urandom_range(0, 5) == 0) begin
                rv = 1'b1;
                case ($urandom_range(0, 3))
                    0:       rd = 8'd0;
                    1:       rd = 8'd255;
                    2:       rd = 8'(m_duty);
                    default: rd = 8'($urandom_range(0, 255));
                endcase
            end
            cycle(rr, ren, rv, rd);
            if (m_accepted || rr) rv = 1'b0;
        end
        cycle(1'b0, 1'b1, 1'b0, 8'd0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d scoreboard entries never checked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
